// File: rtl/logistic_regression_hls_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : logistic_regression_hls_deadlock_monitor
// Brief    : Per-process dataflow deadlock monitor with debounced detection,
//            stall counter and blocked-channel capture. Optional statistics
//            enabled by macro DL_MONITOR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module logistic_regression_hls_deadlock_monitor #(
  parameter int PROC_NUM     = 4,
  parameter int PROC_ID      = 0,
  parameter int IN_CHAN_NUM  = 2,
  parameter int OUT_CHAN_NUM = 3,
  parameter int STALL_THRESH = 4,
  parameter int CNT_W        = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic [CNT_W-1:0]                stall_cnt,
  output logic [OUT_CHAN_NUM-1:0]         blocked_chan_vec,
  output logic [15:0]                     dl_event_cnt,
  output logic [PROC_NUM-1:0]             dl_dep_snapshot
);

  localparam logic [PROC_NUM-1:0] c_self_bit = PROC_NUM'(1) << PROC_ID;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_DETECTED = 2'd2
  } state_t;

  state_t                  r_state;
  logic [PROC_NUM-1:0]     r_dep_reg;
  logic [OUT_CHAN_NUM-1:0] r_token_out;
  logic                    r_dl_detect;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [OUT_CHAN_NUM-1:0] r_blocked;

  logic [PROC_NUM-1:0]     w_dep_comb;
  logic [PROC_NUM-1:0]     w_dep;
  logic                    w_freeze;
  logic                    w_blocked_any;
  logic                    w_self_dep;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_enter_det;

  always_comb begin
    w_dep_comb = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      w_dep_comb = w_dep_comb |
                   ({PROC_NUM{in_chan_dep_vld_vec[i]}} & in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM]);
    end
  end

  // While a global deadlock is declared and no token is circulating, hold the last dependency view.
  assign w_freeze      = dl_detect_in & ~|token_in_vec;
  assign w_dep         = w_freeze ? r_dep_reg : w_dep_comb;
  assign w_blocked_any = |proc_dep_vld_vec;
  assign w_self_dep    = w_dep[PROC_ID] & w_blocked_any & ~w_freeze;
  assign w_cnt_inc     = r_stall_cnt + CNT_W'(1);
  assign w_enter_det   = ~token_clear & w_self_dep &
                         (((r_state == S_IDLE) && (STALL_THRESH == 1)) ||
                          ((r_state == S_ARMED) && (w_cnt_inc >= CNT_W'(STALL_THRESH))));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_dep_reg   <= '0;
      r_token_out <= '0;
      r_dl_detect <= 1'b0;
      r_stall_cnt <= '0;
      r_blocked   <= '0;
    end else begin
      r_dep_reg   <= w_blocked_any ? w_dep : '0;
      r_token_out <= ((|token_in_vec & ~token_clear) | origin | w_enter_det) ? proc_dep_vld_vec : '0;
      if (w_enter_det) begin
        r_blocked <= proc_dep_vld_vec;
      end
      case (r_state)
        S_IDLE: begin
          if (!token_clear && w_self_dep) begin
            r_stall_cnt <= CNT_W'(1);
            if (w_enter_det) begin
              r_state     <= S_DETECTED;
              r_dl_detect <= 1'b1;
            end else begin
              r_state <= S_ARMED;
            end
          end else begin
            r_stall_cnt <= '0;
          end
        end
        S_ARMED: begin
          if (token_clear || !w_self_dep) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= w_cnt_inc;
            if (w_enter_det) begin
              r_state     <= S_DETECTED;
              r_dl_detect <= 1'b1;
            end
          end
        end
        S_DETECTED: begin
          // Latched: only token_clear exits, the counter keeps running and saturates.
          if (token_clear) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_dl_detect <= 1'b0;
          end else if (r_stall_cnt != {CNT_W{1'b1}}) begin
            r_stall_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_stall_cnt <= '0;
          r_dl_detect <= 1'b0;
        end
      endcase
    end
  end

`ifdef DL_MONITOR_STATS_EN
  logic [15:0]         r_event_cnt;
  logic [PROC_NUM-1:0] r_snapshot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_event_cnt <= '0;
      r_snapshot  <= '0;
    end else if (w_enter_det) begin
      r_snapshot <= w_dep;
      if (r_event_cnt != 16'hFFFF) begin
        r_event_cnt <= r_event_cnt + 16'd1;
      end
    end
  end

  assign dl_event_cnt    = r_event_cnt;
  assign dl_dep_snapshot = r_snapshot;
`else
  assign dl_event_cnt    = '0;
  assign dl_dep_snapshot = '0;
`endif

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = r_dep_reg | c_self_bit;
  assign token_out_vec        = r_token_out;
  assign dl_detect_out        = r_dl_detect;
  assign stall_cnt            = r_stall_cnt;
  assign blocked_chan_vec     = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_logistic_regression_hls_deadlock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_logistic_regression_hls_deadlock_monitor
// Brief    : Self-checking bench: directed scenarios plus randomized stimulus
//            against a cycle-level reference model. Honors DL_MONITOR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logistic_regression_hls_deadlock_monitor;

  localparam int PN = 4;
  localparam int ID = 0;
  localparam int IC = 2;
  localparam int OC = 3;
  localparam int TH = 4;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [OC-1:0]   proc_dep_vld_vec;
  logic [IC-1:0]   in_chan_dep_vld_vec;
  logic [IC*PN-1:0] in_chan_dep_data_vec;
  logic [IC-1:0]   token_in_vec;
  logic            dl_detect_in;
  logic            origin;
  logic            token_clear;
  logic [OC-1:0]   out_chan_dep_vld_vec;
  logic [PN-1:0]   out_chan_dep_data;
  logic [OC-1:0]   token_out_vec;
  logic            dl_detect_out;
  logic [CW-1:0]   stall_cnt;
  logic [OC-1:0]   blocked_chan_vec;
  logic [15:0]     dl_event_cnt;
  logic [PN-1:0]   dl_dep_snapshot;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PN-1:0] m_dep_reg;
  bit            m_det;
  int            m_run;
  int            m_cnt;
  logic [OC-1:0] m_tok;
  logic [OC-1:0] m_blocked;
  int            m_events;
  logic [PN-1:0] m_snap;

  logistic_regression_hls_deadlock_monitor #(
    .PROC_NUM(PN), .PROC_ID(ID), .IN_CHAN_NUM(IC), .OUT_CHAN_NUM(OC),
    .STALL_THRESH(TH), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(proc_dep_vld_vec),
    .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
    .in_chan_dep_data_vec(in_chan_dep_data_vec),
    .token_in_vec(token_in_vec),
    .dl_detect_in(dl_detect_in),
    .origin(origin),
    .token_clear(token_clear),
    .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
    .out_chan_dep_data(out_chan_dep_data),
    .token_out_vec(token_out_vec),
    .dl_detect_out(dl_detect_out),
    .stall_cnt(stall_cnt),
    .blocked_chan_vec(blocked_chan_vec),
    .dl_event_cnt(dl_event_cnt),
    .dl_dep_snapshot(dl_dep_snapshot)
  );

  always #5 clock = ~clock;

  task automatic reset_model();
    m_dep_reg = '0; m_det = 0; m_run = 0; m_cnt = 0;
    m_tok = '0; m_blocked = '0; m_events = 0; m_snap = '0;
  endtask

  task automatic zero_inputs();
    proc_dep_vld_vec = '0; in_chan_dep_vld_vec = '0; in_chan_dep_data_vec = '0;
    token_in_vec = '0; dl_detect_in = 0; origin = 0; token_clear = 0;
  endtask

  // Advances the model by one clock using the current inputs, then clocks the DUT.
  task automatic tick();
    logic [PN-1:0] comb;
    logic [PN-1:0] dep;
    bit frz, sd, enter;
    comb = '0;
    for (int i = 0; i < IC; i++)
      if (in_chan_dep_vld_vec[i]) comb = comb | in_chan_dep_data_vec[i*PN +: PN];
    frz   = dl_detect_in && (token_in_vec == '0);
    dep   = frz ? m_dep_reg : comb;
    sd    = dep[ID] && (proc_dep_vld_vec != '0) && !frz;
    enter = 0;
    if (token_clear) begin
      m_run = 0; m_det = 0; m_cnt = 0;
    end else if (m_det) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (sd) begin
      m_run++;
      m_cnt = m_run;
      if (m_run >= TH) begin m_det = 1; enter = 1; end
    end else begin
      m_run = 0; m_cnt = 0;
    end
    m_tok = (((token_in_vec != '0) && !token_clear) || origin || enter) ? proc_dep_vld_vec : '0;
    if (enter) begin
      m_blocked = proc_dep_vld_vec;
      m_snap    = dep;
      if (m_events < 65535) m_events++;
    end
    m_dep_reg = (proc_dep_vld_vec != '0) ? dep : '0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      proc_dep_vld_vec     = OC'($urandom);
      in_chan_dep_vld_vec  = IC'($urandom);
      in_chan_dep_data_vec = (IC*PN)'($urandom);
      token_in_vec         = IC'($urandom);
      dl_detect_in         = 1'($urandom);
      origin               = 1'($urandom);
      token_clear          = 1'($urandom);
      @(posedge clock); #1;
      checks++;
      if (dl_detect_out !== 1'b0 || stall_cnt !== '0 || token_out_vec !== '0 ||
          blocked_chan_vec !== '0 || dl_event_cnt !== '0 || dl_dep_snapshot !== '0) begin
        errors++;
        $display("FAIL reset_regs: det=%0b cnt=%0h tok=%0h blk=%0h ev=%0h snap=%0h, required all 0",
                 dl_detect_out, stall_cnt, token_out_vec, blocked_chan_vec, dl_event_cnt, dl_dep_snapshot);
      end
      checks++;
      if (out_chan_dep_data !== 4'b0001 || out_chan_dep_vld_vec !== proc_dep_vld_vec) begin
        errors++;
        $display("FAIL reset_comb: data=%0h vld=%0h, required 1 / %0h",
                 out_chan_dep_data, out_chan_dep_vld_vec, proc_dep_vld_vec);
      end
    end
    zero_inputs();
    @(negedge clock) reset = 1'b1;
    reset_model();
    tick();
  endtask

  task automatic set_self_dep_stim();
    proc_dep_vld_vec     = 3'b001;
    in_chan_dep_vld_vec  = 2'b01;
    in_chan_dep_data_vec = 8'h01;
  endtask

  task automatic test_detect();
    set_self_dep_stim();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (dl_detect_out !== (k == 4) || stall_cnt !== CW'(k)) begin
        errors++;
        $display("FAIL detect_debounce[%0d]: det=%0b cnt=%0d, required %0b / %0d",
                 k, dl_detect_out, stall_cnt, (k == 4), k);
      end
    end
    checks++;
    if (token_out_vec !== 3'b001 || blocked_chan_vec !== 3'b001 || out_chan_dep_data !== 4'b0001) begin
      errors++;
      $display("FAIL detect_entry: tok=%0h blk=%0h data=%0h, required 1 / 1 / 1",
               token_out_vec, blocked_chan_vec, out_chan_dep_data);
    end
    tick();
    checks++;
    if (token_out_vec !== 3'b000 || dl_detect_out !== 1'b1 || stall_cnt !== CW'(5)) begin
      errors++;
      $display("FAIL detect_hold: tok=%0h det=%0b cnt=%0d, required 0 / 1 / 5",
               token_out_vec, dl_detect_out, stall_cnt);
    end
    zero_inputs();
    token_clear = 1'b1;
    tick();
    token_clear = 1'b0;
  endtask

  task automatic test_drop();
    set_self_dep_stim();
    repeat (3) tick();
    checks++;
    if (stall_cnt !== CW'(3)) begin
      errors++;
      $display("FAIL drop_armed: cnt=%0d, required 3", stall_cnt);
    end
    in_chan_dep_data_vec = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (stall_cnt !== '0 || dl_detect_out !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle[%0d]: cnt=%0d det=%0b, required 0 / 0", k, stall_cnt, dl_detect_out);
      end
    end
    zero_inputs();
  endtask

  task automatic test_clear();
    set_self_dep_stim();
    repeat (4) tick();
    zero_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (dl_detect_out !== 1'b1 || stall_cnt !== CW'(5 + k)) begin
        errors++;
        $display("FAIL clear_latched[%0d]: det=%0b cnt=%0d, required 1 / %0d", k, dl_detect_out, stall_cnt, 5 + k);
      end
    end
    token_clear = 1'b1;
    tick();
    token_clear = 1'b0;
    checks++;
    if (dl_detect_out !== 1'b0 || stall_cnt !== '0 || blocked_chan_vec !== 3'b001) begin
      errors++;
      $display("FAIL clear_release: det=%0b cnt=%0d blk=%0h, required 0 / 0 / 1",
               dl_detect_out, stall_cnt, blocked_chan_vec);
    end
  endtask

  task automatic test_freeze();
    proc_dep_vld_vec     = 3'b001;
    in_chan_dep_vld_vec  = 2'b01;
    in_chan_dep_data_vec = 8'h06;
    tick();
    dl_detect_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_chan_dep_vld_vec  = 2'b11;
      in_chan_dep_data_vec = 8'h01 | 8'($urandom);
      tick();
      checks++;
      if (out_chan_dep_data !== 4'b0111 || dl_detect_out !== 1'b0 || stall_cnt !== '0) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: data=%0h det=%0b cnt=%0d, required 7 / 0 / 0",
                 k, out_chan_dep_data, dl_detect_out, stall_cnt);
      end
    end
    token_in_vec     = 2'b10;
    proc_dep_vld_vec = 3'b101;
    tick();
    checks++;
    if (token_out_vec !== 3'b101) begin
      errors++;
      $display("FAIL freeze_token: tok=%0h, required 5", token_out_vec);
    end
    zero_inputs();
    token_clear = 1'b1;
    tick();
    token_clear = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0]   exp_ev;
    logic [PN-1:0] exp_snap;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 20) begin
        proc_dep_vld_vec     = OC'($urandom_range(0, 7));
        in_chan_dep_vld_vec  = IC'($urandom);
        in_chan_dep_data_vec = (IC*PN)'($urandom);
      end
      token_clear  = ($urandom_range(0, 99) < 4);
      dl_detect_in = ($urandom_range(0, 99) < 10);
      origin       = ($urandom_range(0, 99) < 5);
      token_in_vec = ($urandom_range(0, 99) < 15) ? IC'($urandom) : '0;
      tick();
`ifdef DL_MONITOR_STATS_EN
      exp_ev = 16'(m_events); exp_snap = m_snap;
`else
      exp_ev = '0; exp_snap = '0;
`endif
      checks++;
      if (dl_detect_out !== m_det || stall_cnt !== CW'(m_cnt) || token_out_vec !== m_tok ||
          blocked_chan_vec !== m_blocked || out_chan_dep_data !== (m_dep_reg | 4'b0001) ||
          out_chan_dep_vld_vec !== proc_dep_vld_vec || dl_event_cnt !== exp_ev || dl_dep_snapshot !== exp_snap) begin
        errors++;
        $display("FAIL random[%0d]: det=%0b/%0b cnt=%0d/%0d tok=%0h/%0h blk=%0h/%0h data=%0h/%0h ev=%0d/%0d snap=%0h/%0h (got/required)",
                 k, dl_detect_out, m_det, stall_cnt, m_cnt, token_out_vec, m_tok, blocked_chan_vec, m_blocked,
                 out_chan_dep_data, m_dep_reg | 4'b0001, dl_event_cnt, exp_ev, dl_dep_snapshot, exp_snap);
      end
    end
    zero_inputs();
    token_clear = 1'b1;
    tick();
    token_clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_self_dep_stim();
    origin = 1'b1;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dl_detect_out !== 1'b0 || stall_cnt !== '0 || token_out_vec !== '0 ||
        blocked_chan_vec !== '0 || out_chan_dep_data !== 4'b0001 || dl_event_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid: det=%0b cnt=%0d tok=%0h blk=%0h data=%0h ev=%0d, required 0/0/0/0/1/0",
               dl_detect_out, stall_cnt, token_out_vec, blocked_chan_vec, out_chan_dep_data, dl_event_cnt);
    end
    zero_inputs();
    @(negedge clock) reset = 1'b1;
    reset_model();
    tick();
  endtask

  task automatic test_stats();
    logic [7:0]    last_data;
    logic [15:0]   exp_ev;
    logic [PN-1:0] exp_snap;
    last_data = 8'h01;
    for (int r = 0; r < 3; r++) begin
      last_data            = 8'h01 | 8'($urandom_range(0, 15));
      proc_dep_vld_vec     = 3'b011;
      in_chan_dep_vld_vec  = 2'b01;
      in_chan_dep_data_vec = last_data;
      repeat (4) tick();
      zero_inputs();
      token_clear = 1'b1;
      tick();
      token_clear = 1'b0;
    end
`ifdef DL_MONITOR_STATS_EN
    exp_ev = 16'd3; exp_snap = last_data[PN-1:0];
`else
    exp_ev = 16'd0; exp_snap = '0;
`endif
    checks++;
    if (dl_event_cnt !== exp_ev || dl_dep_snapshot !== exp_snap) begin
      errors++;
      $display("FAIL stats: ev=%0d snap=%0h, required %0d / %0h", dl_event_cnt, dl_dep_snapshot, exp_ev, exp_snap);
    end
    checks++;
    if (blocked_chan_vec !== 3'b011 || dl_detect_out !== 1'b0) begin
      errors++;
      $display("FAIL stats_blocked: blk=%0h det=%0b, required 3 / 0", blocked_chan_vec, dl_detect_out);
    end
  endtask

  initial begin
    zero_inputs();
    reset_model();
    test_reset();
    test_detect();
    test_drop();
    test_clear();
    test_freeze();
    test_random();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
